// File: rtl/decap_pkg.sv
// Shared types and byte-lane helpers for the packet decapsulator.
package decap_pkg;

    localparam int DATA_BYTES = 4;

    typedef enum logic [1:0] {
        HDR,
        PAYLOAD,
        FLUSH,
        DROP
    } state_t;

    // Contiguous keep (from bit 0) to byte count; non-contiguous patterns read as empty.
    function automatic logic [2:0] keep_to_count(input logic [3:0] keep);
        case (keep)
            4'b0001: return 3'd1;
            4'b0011: return 3'd2;
            4'b0111: return 3'd3;
            4'b1111: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Byte count to contiguous keep; anything from 4 up means a full word.
    function automatic logic [3:0] count_to_keep(input logic [2:0] count);
        case (count)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // Expand a keep vector into a bit mask over the data word.
    function automatic logic [31:0] keep_to_mask(input logic [3:0] keep);
        return {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
    endfunction

endpackage

// File: rtl/decap_realign.sv
// Combinational byte shifter: appends the kept input bytes behind the held
// bytes, returns the low word, the spill-over for the hold register and the
// total number of valid bytes (0..7).
module decap_realign
    import decap_pkg::*;
(
    input  logic [31:0] hold,
    input  logic [1:0]  hold_bytes,
    input  logic [31:0] data,
    input  logic [3:0]  keep,
    output logic [31:0] word,
    output logic [3:0]  word_keep,
    output logic [31:0] next_hold,
    output logic [2:0]  total
);

    logic [31:0] hold_masked;
    logic [31:0] data_masked;
    logic [63:0] combined;

    // Unused byte lanes are zeroed so emitted words never carry stale bytes.
    assign hold_masked = hold & keep_to_mask(count_to_keep({1'b0, hold_bytes}));
    assign data_masked = data & keep_to_mask(keep);
    assign combined    = {32'b0, hold_masked} | ({32'b0, data_masked} << {hold_bytes, 3'b000});

    assign total     = {1'b0, hold_bytes} + keep_to_count(keep);
    assign word      = combined[31:0];
    assign word_keep = count_to_keep(total);
    assign next_hold = combined[63:32];

endmodule

// File: rtl/packet_decapsulator.sv
// Strips a fixed HDR_BYTES outer header from each AXI4-Stream packet and
// re-emits the payload aligned to byte 0, with drop and runt handling.
module packet_decapsulator
    import decap_pkg::*;
#(
    parameter int HDR_BYTES = 28,
    parameter int CNT_W     = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             drop,
    input  logic [31:0]      s_axis_tdata,
    input  logic [3:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] runt_count
);

    // Whole header words, and header bytes spilling into the first payload word.
    localparam int         HW      = HDR_BYTES / DATA_BYTES;
    localparam int         SH      = HDR_BYTES % DATA_BYTES;
    localparam logic [7:0] HW_BEAT = 8'(HW);
    localparam logic [1:0] SH_HOLD = 2'(DATA_BYTES - SH);
    localparam logic [2:0] SH_CNT  = 3'(SH);

    state_t           state, state_nxt;
    logic [7:0]       beat_cnt, beat_nxt;
    logic [31:0]      hold, hold_nxt;
    logic [1:0]       hold_cnt, hold_cnt_nxt;
    logic [31:0]      m_data_nxt;
    logic [3:0]       m_keep_nxt;
    logic             m_valid_nxt, m_last_nxt;
    logic [CNT_W-1:0] pkt_nxt, drop_nxt, runt_nxt;

    logic             out_free;
    logic             payload_beat;
    logic [31:0]      tail_data;
    logic [2:0]       tail_cnt;
    logic [31:0]      rl_word, rl_hold;
    logic [3:0]       rl_keep;
    logic [2:0]       rl_total;

    decap_realign u_realign (
        .hold       (hold),
        .hold_bytes (hold_cnt),
        .data       (s_axis_tdata),
        .keep       (s_axis_tkeep),
        .word       (rl_word),
        .word_keep  (rl_keep),
        .next_hold  (rl_hold),
        .total      (rl_total)
    );

    // The output register may take a new beat when empty or being drained.
    assign out_free  = !m_axis_tvalid || m_axis_tready;
    // Bytes of the last header-bearing word that belong to the payload.
    assign tail_data = (s_axis_tdata & keep_to_mask(s_axis_tkeep)) >> (8 * SH);
    assign tail_cnt  = keep_to_count(s_axis_tkeep);

    // Next-state, input ready, output register and counter updates.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (which would infer a latch).
        state_nxt     = state;
        beat_nxt      = beat_cnt;
        hold_nxt      = hold;
        hold_cnt_nxt  = hold_cnt;
        m_data_nxt    = m_axis_tdata;
        m_keep_nxt    = m_axis_tkeep;
        m_valid_nxt   = m_axis_tvalid && !m_axis_tready;
        m_last_nxt    = m_axis_tlast;
        pkt_nxt       = pkt_count;
        drop_nxt      = drop_count;
        runt_nxt      = runt_count;
        s_axis_tready = 1'b0;
        payload_beat  = 1'b0;

        case (state)
            HDR: begin
                // The payload-start beat may produce output, so it waits for space.
                s_axis_tready = (beat_cnt == HW_BEAT) ? out_free : 1'b1;
                if (s_axis_tvalid && s_axis_tready) begin
                    if (beat_cnt == 8'd0 && drop) begin
                        if (s_axis_tlast) drop_nxt = drop_count + 1'b1;
                        else              state_nxt = DROP;
                    end else if (beat_cnt != HW_BEAT) begin
                        if (s_axis_tlast) begin
                            runt_nxt = runt_count + 1'b1;
                            beat_nxt = 8'd0;
                        end else begin
                            beat_nxt = beat_cnt + 8'd1;
                        end
                    end else begin
                        beat_nxt = 8'd0;
                        if (SH == 0) begin
                            payload_beat = 1'b1;
                        end else if (!s_axis_tlast) begin
                            hold_nxt     = tail_data;
                            hold_cnt_nxt = SH_HOLD;
                            state_nxt    = PAYLOAD;
                        end else if (tail_cnt > SH_CNT) begin
                            m_data_nxt  = tail_data;
                            m_keep_nxt  = count_to_keep(tail_cnt - SH_CNT);
                            m_valid_nxt = 1'b1;
                            m_last_nxt  = 1'b1;
                            pkt_nxt     = pkt_count + 1'b1;
                        end else begin
                            runt_nxt = runt_count + 1'b1;
                        end
                    end
                end
            end
            PAYLOAD: begin
                s_axis_tready = out_free;
                payload_beat  = s_axis_tvalid && out_free;
            end
            FLUSH: begin
                if (out_free) begin
                    m_data_nxt   = hold;
                    m_keep_nxt   = count_to_keep({1'b0, hold_cnt});
                    m_valid_nxt  = 1'b1;
                    m_last_nxt   = 1'b1;
                    pkt_nxt      = pkt_count + 1'b1;
                    hold_cnt_nxt = 2'd0;
                    state_nxt    = HDR;
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_nxt  = drop_count + 1'b1;
                    state_nxt = HDR;
                end
            end
            default: state_nxt = HDR;
        endcase

        // Shared handling of an accepted payload beat (hold bytes + input bytes).
        if (payload_beat) begin
            if (!s_axis_tlast) begin
                m_data_nxt   = rl_word;
                m_keep_nxt   = rl_keep;
                m_valid_nxt  = 1'b1;
                m_last_nxt   = 1'b0;
                hold_nxt     = rl_hold;
                hold_cnt_nxt = 2'(rl_total - 3'd4);
                state_nxt    = PAYLOAD;
            end else if (rl_total == 3'd0) begin
                runt_nxt     = runt_count + 1'b1;
                hold_cnt_nxt = 2'd0;
                state_nxt    = HDR;
            end else if (rl_total <= 3'd4) begin
                m_data_nxt   = rl_word;
                m_keep_nxt   = rl_keep;
                m_valid_nxt  = 1'b1;
                m_last_nxt   = 1'b1;
                pkt_nxt      = pkt_count + 1'b1;
                hold_cnt_nxt = 2'd0;
                state_nxt    = HDR;
            end else begin
                m_data_nxt   = rl_word;
                m_keep_nxt   = rl_keep;
                m_valid_nxt  = 1'b1;
                m_last_nxt   = 1'b0;
                hold_nxt     = rl_hold;
                hold_cnt_nxt = 2'(rl_total - 3'd4);
                state_nxt    = FLUSH;
            end
        end
    end

    // State, hold register, output register and counters; reset abandons any packet.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (areset) begin
            state         <= HDR;
            beat_cnt      <= 8'd0;
            hold          <= 32'd0;
            hold_cnt      <= 2'd0;
            m_axis_tdata  <= 32'd0;
            m_axis_tkeep  <= 4'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            pkt_count     <= '0;
            drop_count    <= '0;
            runt_count    <= '0;
        end else begin
            state         <= state_nxt;
            beat_cnt      <= beat_nxt;
            hold          <= hold_nxt;
            hold_cnt      <= hold_cnt_nxt;
            m_axis_tdata  <= m_data_nxt;
            m_axis_tkeep  <= m_keep_nxt;
            m_axis_tvalid <= m_valid_nxt;
            m_axis_tlast  <= m_last_nxt;
            pkt_count     <= pkt_nxt;
            drop_count    <= drop_nxt;
            runt_count    <= runt_nxt;
        end
    end

endmodule

// File: tb/tb_packet_decapsulator.sv
// Directed bench: two decapsulators (28-byte and 30-byte headers) share clock
// and reset; input bytes are a running sequence so payload bytes are predictable.
module tb_packet_decapsulator;

    logic        aclk = 1'b0;
    logic        areset;
    logic        drop      [2];
    logic [31:0] s_data    [2];
    logic [3:0]  s_keep    [2];
    logic        s_valid   [2];
    logic        s_ready   [2];
    logic        s_last    [2];
    logic [31:0] m_data    [2];
    logic [3:0]  m_keep    [2];
    logic        m_valid   [2];
    logic        m_ready   [2];
    logic        m_last    [2];
    logic [15:0] pkt_cnt   [2];
    logic [15:0] drop_cnt  [2];
    logic [15:0] runt_cnt  [2];

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t prev_beat [2];
    logic  prev_stall[2];
    int    stall_err = 0;
    int    n_checks  = 0;
    int    n_pass    = 0;
    int    n_fail    = 0;
    logic  rand_mode = 1'b0;

    packet_decapsulator #(.HDR_BYTES(28), .CNT_W(16)) dut0 (
        .aclk(aclk), .areset(areset), .drop(drop[0]),
        .s_axis_tdata(s_data[0]), .s_axis_tkeep(s_keep[0]), .s_axis_tvalid(s_valid[0]),
        .s_axis_tready(s_ready[0]), .s_axis_tlast(s_last[0]),
        .m_axis_tdata(m_data[0]), .m_axis_tkeep(m_keep[0]), .m_axis_tvalid(m_valid[0]),
        .m_axis_tready(m_ready[0]), .m_axis_tlast(m_last[0]),
        .pkt_count(pkt_cnt[0]), .drop_count(drop_cnt[0]), .runt_count(runt_cnt[0])
    );

    packet_decapsulator #(.HDR_BYTES(30), .CNT_W(16)) dut1 (
        .aclk(aclk), .areset(areset), .drop(drop[1]),
        .s_axis_tdata(s_data[1]), .s_axis_tkeep(s_keep[1]), .s_axis_tvalid(s_valid[1]),
        .s_axis_tready(s_ready[1]), .s_axis_tlast(s_last[1]),
        .m_axis_tdata(m_data[1]), .m_axis_tkeep(m_keep[1]), .m_axis_tvalid(m_valid[1]),
        .m_axis_tready(m_ready[1]), .m_axis_tlast(m_last[1]),
        .pkt_count(pkt_cnt[1]), .drop_count(drop_cnt[1]), .runt_count(runt_cnt[1])
    );

    always #5 aclk = ~aclk;

    // Output ready: constant 1, or a coin flip per cycle in random mode.
    initial begin
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_ready[0] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready[1] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Capture output handshakes mid-cycle and flag any change while stalled.
    always @(negedge aclk) begin
        for (int i = 0; i < 2; i++) begin
            if (areset) begin
                prev_stall[i] = 1'b0;
            end else begin
                if (prev_stall[i] &&
                    (m_valid[i] !== 1'b1 || {m_data[i], m_keep[i], m_last[i]} !== prev_beat[i]))
                    stall_err++;
                if (m_valid[i] && m_ready[i]) begin
                    if (i == 0) q0.push_back({m_data[i], m_keep[i], m_last[i]});
                    else        q1.push_back({m_data[i], m_keep[i], m_last[i]});
                end
                prev_stall[i] = m_valid[i] && !m_ready[i];
                prev_beat[i]  = {m_data[i], m_keep[i], m_last[i]};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] word_of(input logic [7:0] base, input int i);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(int'(base) + 4 * i + b);
        return w;
    endfunction

    task automatic do_reset();
        @(posedge aclk);
        #1;
        areset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0;
            drop[i]    = 1'b0;
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic send_beat(input int sel, input logic [31:0] d, input logic [3:0] k,
                             input logic l, input logic dr);
        int   cyc;
        logic acc;
        s_data[sel]  = d;
        s_keep[sel]  = k;
        s_last[sel]  = l;
        drop[sel]    = dr;
        s_valid[sel] = 1'b1;
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 500) begin
            @(negedge aclk);
            acc = s_ready[sel];
            @(posedge aclk);
            #1;
            cyc++;
        end
        s_valid[sel] = 1'b0;
        drop[sel]    = 1'b0;
        if (!acc) check("input_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_pkt(input int sel, input logic [7:0] base, input int nwords,
                            input logic [3:0] last_keep, input logic dr);
        for (int i = 0; i < nwords; i++)
            send_beat(sel, word_of(base, i), (i == nwords - 1) ? last_keep : 4'hF,
                      i == nwords - 1, (i == 0) ? dr : 1'b0);
    endtask

    // Wait for the expected beats, allow time for extras, then compare every beat.
    task automatic expect_pkt(input int sel, input logic [7:0] base, input int hdr,
                              input int nbytes, input string tag);
        int    nbeats;
        int    cyc;
        int    nb;
        beat_t b;
        logic [31:0] exp_data;
        nbeats = (nbytes + 3) / 4;
        cyc = 0;
        while (qsize(sel) < nbeats && cyc < 3000) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        repeat (12) @(posedge aclk);
        #1;
        check($sformatf("%s_beats", tag), 32'(qsize(sel)), 32'(nbeats));
        for (int k = 0; k < nbeats && k < qsize(sel); k++) begin
            b  = (sel == 0) ? q0[k] : q1[k];
            nb = nbytes - 4 * k;
            if (nb > 4) nb = 4;
            exp_data = 32'd0;
            for (int j = 0; j < nb; j++) exp_data[8*j +: 8] = 8'(int'(base) + hdr + 4 * k + j);
            check($sformatf("%s_data%0d", tag, k), b.data, exp_data);
            check($sformatf("%s_keep%0d", tag, k), 32'(b.keep), 32'(4'((5'd1 << nb) - 5'd1)));
            check($sformatf("%s_last%0d", tag, k), 32'(b.last), 32'(k == nbeats - 1));
        end
        if (sel == 0) q0.delete();
        else          q1.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        areset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drop[i] = 1'b0; s_data[i] = 32'd0; s_keep[i] = 4'd0;
            s_valid[i] = 1'b0; s_last[i] = 1'b0; prev_stall[i] = 1'b0;
        end
        do_reset();

        // Reset state of both instances.
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_s_ready%0d", i), 32'(s_ready[i]), 32'd1);
            check($sformatf("rst_m_valid%0d", i), 32'(m_valid[i]), 32'd0);
            check($sformatf("rst_m_last%0d", i),  32'(m_last[i]),  32'd0);
            check($sformatf("rst_m_keep%0d", i),  32'(m_keep[i]),  32'd0);
            check($sformatf("rst_m_data%0d", i),  m_data[i],       32'd0);
            check($sformatf("rst_pkt%0d", i),     32'(pkt_cnt[i]),  32'd0);
            check($sformatf("rst_drop%0d", i),    32'(drop_cnt[i]), 32'd0);
            check($sformatf("rst_runt%0d", i),    32'(runt_cnt[i]), 32'd0);
        end

        // Case 1: word-aligned header, 74 bytes in -> 46 payload bytes.
        send_pkt(0, 8'h00, 19, 4'b0011, 1'b0);
        expect_pkt(0, 8'h00, 28, 46, "c1");
        check("c1_pkt", 32'(pkt_cnt[0]), 32'd1);

        // Case 2: 30-byte header, 76 bytes in -> 46 bytes with a flush beat.
        send_pkt(1, 8'h10, 19, 4'hF, 1'b0);
        expect_pkt(1, 8'h10, 30, 46, "c2");
        check("c2_pkt", 32'(pkt_cnt[1]), 32'd1);
        check("c2_runt", 32'(runt_cnt[1]), 32'd0);

        // Case 3: dropped packet followed by a normal one.
        do_reset();
        send_pkt(0, 8'h20, 19, 4'hF, 1'b1);
        send_pkt(0, 8'h40, 19, 4'hF, 1'b0);
        expect_pkt(0, 8'h40, 28, 48, "c3");
        check("c3_drop", 32'(drop_cnt[0]), 32'd1);
        check("c3_pkt",  32'(pkt_cnt[0]),  32'd1);

        // Case 4: 20-byte runt, exactly-header 28-byte runt, then a 45-byte payload.
        do_reset();
        send_pkt(0, 8'h50, 5, 4'hF, 1'b0);
        send_pkt(0, 8'h60, 7, 4'hF, 1'b0);
        send_pkt(0, 8'h70, 19, 4'b0001, 1'b0);
        expect_pkt(0, 8'h70, 28, 45, "c4");
        check("c4_runt", 32'(runt_cnt[0]), 32'd2);
        check("c4_pkt",  32'(pkt_cnt[0]),  32'd1);

        // Unaligned header: tlast on the split word with 0 and with 2 payload bytes.
        send_pkt(1, 8'h80, 8, 4'b0011, 1'b0);
        send_pkt(1, 8'h90, 8, 4'hF, 1'b0);
        expect_pkt(1, 8'h90, 30, 2, "c4b");
        check("c4b_runt", 32'(runt_cnt[1]), 32'd1);
        check("c4b_pkt",  32'(pkt_cnt[1]),  32'd1);

        // Case 5: random output backpressure on both header alignments.
        do_reset();
        rand_mode = 1'b1;
        send_pkt(0, 8'hA0, 19, 4'b0011, 1'b0);
        expect_pkt(0, 8'hA0, 28, 46, "c5");
        send_pkt(1, 8'hB0, 19, 4'hF, 1'b0);
        expect_pkt(1, 8'hB0, 30, 46, "c5b");
        rand_mode = 1'b0;
        check("c5_pkt",   32'(pkt_cnt[0]), 32'd1);
        check("c5b_pkt",  32'(pkt_cnt[1]), 32'd1);
        check("c5_stall", 32'(stall_err),  32'd0);

        // Case 6: reset in the middle of a packet, then a fresh packet.
        do_reset();
        for (int i = 0; i < 10; i++) send_beat(0, word_of(8'hC0, i), 4'hF, 1'b0, 1'b0);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check("c6_m_valid", 32'(m_valid[0]),  32'd0);
        check("c6_s_ready", 32'(s_ready[0]),  32'd1);
        check("c6_pkt",     32'(pkt_cnt[0]),  32'd0);
        check("c6_drop",    32'(drop_cnt[0]), 32'd0);
        check("c6_runt",    32'(runt_cnt[0]), 32'd0);
        q0.delete();
        send_pkt(0, 8'hD0, 19, 4'b0011, 1'b0);
        expect_pkt(0, 8'hD0, 28, 46, "c6");
        check("c6_pkt_after", 32'(pkt_cnt[0]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
